// File: rtl/vstream_pkg.sv
// Shared types and constants for the vector_streamer operand buffer.
package vstream_pkg;

    typedef enum logic [1:0] {IDLE, PRIME, STREAM, WAIT} vs_state_t;

    localparam int VS_ELEM_W = 8;

endpackage

// File: rtl/vector_streamer_vec_mem.sv
// Dual operand store (A and B) with one write port and a shared read index.
// Read data is registered and only advances when rd_en is high.
module vec_mem
    import vstream_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 wr_en,
    input  logic                 wr_sel,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [VS_ELEM_W-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [VS_ELEM_W-1:0] rd_a,
    output logic [VS_ELEM_W-1:0] rd_b
);

    logic [VS_ELEM_W-1:0] mem_a [DEPTH];
    logic [VS_ELEM_W-1:0] mem_b [DEPTH];

    // Storage has no reset so the same vectors can be replayed after a reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_sel) mem_b[wr_addr] <= wr_data;
            else        mem_a[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_a <= '0;
            rd_b <= '0;
        end else if (rd_en) begin
            rd_a <= mem_a[rd_addr];
            rd_b <= mem_b[rd_addr];
        end
    end

endmodule

// File: rtl/vector_streamer.sv
// Operand sequencer feeding dot_prod: buffers A/B, then streams N pairs on go.
//   state  | meaning
//   IDLE   | accept writes and go; writes_done low
//   PRIME  | index 0 read in flight; writes_done high
//   STREAM | one A/B pair per cycle with vector_valid
//   WAIT   | stream finished, hold writes_done until acc_done
module vector_streamer
    import vstream_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 wr_en,
    input  logic                 wr_sel,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [VS_ELEM_W-1:0] wr_data,
    input  logic                 go,
    input  logic [31:0]          len,
    input  logic                 acc_done,
    output logic                 writes_done,
    output logic                 vector_valid,
    output logic [VS_ELEM_W-1:0] vector_a_out,
    output logic [VS_ELEM_W-1:0] vector_b_out,
    output logic [31:0]          vector_len,
    output logic                 busy,
    output logic                 err_len
);

    localparam int IDX_W = ADDR_W + 1;

    vs_state_t        state, state_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic [31:0]      len_d;
    logic             err_d;
    logic             rd_en;
    logic             mem_wr;
    logic             len_ok;

    assign len_ok = (len != 32'd0) && (len <= 32'(DEPTH));

    always_comb begin
        state_d = state;
        idx_d   = idx;
        len_d   = vector_len;
        err_d   = err_len;
        rd_en   = 1'b0;
        mem_wr  = 1'b0;
        case (state)
            IDLE: begin
                mem_wr = wr_en;
                if (go) begin
                    if (len_ok) begin
                        len_d   = len;
                        err_d   = 1'b0;
                        idx_d   = '0;
                        state_d = PRIME;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            PRIME: begin
                rd_en   = 1'b1;
                idx_d   = idx + IDX_W'(1);
                state_d = STREAM;
            end
            STREAM: begin
                // idx has IDX_W bits so it reaches DEPTH without wrapping
                if (32'(idx) == vector_len) begin
                    state_d = WAIT;
                end else begin
                    rd_en = 1'b1;
                    idx_d = idx + IDX_W'(1);
                end
            end
            WAIT: begin
                if (acc_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            idx          <= '0;
            vector_len   <= '0;
            err_len      <= 1'b0;
            writes_done  <= 1'b0;
            busy         <= 1'b0;
            vector_valid <= 1'b0;
        end else begin
            state        <= state_d;
            idx          <= idx_d;
            vector_len   <= len_d;
            err_len      <= err_d;
            writes_done  <= (state_d != IDLE);
            busy         <= (state_d != IDLE);
            vector_valid <= rd_en;
        end
    end

    vec_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (mem_wr),
        .wr_sel  (wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (idx[ADDR_W-1:0]),
        .rd_a    (vector_a_out),
        .rd_b    (vector_b_out)
    );

endmodule

// File: tb/tb_vector_streamer.sv
// Directed bench for vector_streamer with a shadow copy of the operand memory.
module tb_vector_streamer;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rstn;
    logic        wr_en;
    logic        wr_sel;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        go;
    logic [31:0] len;
    logic        acc_done;
    logic        writes_done;
    logic        vector_valid;
    logic [7:0]  vector_a_out;
    logic [7:0]  vector_b_out;
    logic [31:0] vector_len;
    logic        busy;
    logic        err_len;

    int n_cmp = 0;
    int n_err = 0;
    int dot;

    logic signed [7:0] ma [DEPTH];
    logic signed [7:0] mb [DEPTH];

    vector_streamer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .wr_en        (wr_en),
        .wr_sel       (wr_sel),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .go           (go),
        .len          (len),
        .acc_done     (acc_done),
        .writes_done  (writes_done),
        .vector_valid (vector_valid),
        .vector_a_out (vector_a_out),
        .vector_b_out (vector_b_out),
        .vector_len   (vector_len),
        .busy         (busy),
        .err_len      (err_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit sel, input int addr, input logic signed [7:0] d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = addr[3:0];
        wr_data = d;
        tick();
        wr_en = 1'b0;
        if (sel) mb[addr] = d;
        else     ma[addr] = d;
    endtask

    task automatic go_cmd(input int n);
        go  = 1'b1;
        len = n;
        tick();
        go  = 1'b0;
        len = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wd"},    writes_done,  0);
        chk({tag, "_valid"}, vector_valid, 0);
        chk({tag, "_a"},     vector_a_out, 0);
        chk({tag, "_b"},     vector_b_out, 0);
        chk({tag, "_len"},   vector_len,   0);
        chk({tag, "_busy"},  busy,         0);
        chk({tag, "_err"},   err_len,      0);
    endtask

    // Called right after go was sampled; inj >= 0 pokes write/go/acc_done mid-stream.
    task automatic run(input int n, input int inj, output int d);
        d = 0;
        chk("wd_lead", writes_done, 1);
        chk("busy_lead", busy, 1);
        chk("valid_lead", vector_valid, 0);
        for (int i = 0; i < n; i++) begin
            if (i == inj) begin
                wr_en    = 1'b1;
                wr_sel   = 1'b0;
                wr_addr  = 4'd0;
                wr_data  = 8'd99;
                go       = 1'b1;
                len      = 32'd0;
                acc_done = 1'b1;
            end
            tick();
            wr_en    = 1'b0;
            go       = 1'b0;
            acc_done = 1'b0;
            chk($sformatf("valid%0d", i), vector_valid, 1);
            chk($sformatf("a%0d", i), $signed(vector_a_out), ma[i]);
            chk($sformatf("b%0d", i), $signed(vector_b_out), mb[i]);
            d += int'($signed(vector_a_out)) * int'($signed(vector_b_out));
        end
        tick();
        chk("valid_end", vector_valid, 0);
        chk("wd_hold", writes_done, 1);
    endtask

    task automatic finish_acc;
        tick();
        chk("wd_wait", writes_done, 1);
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        chk("wd_clr", writes_done, 0);
        chk("busy_clr", busy, 0);
    endtask

    initial begin
        clk = 1'b0; rstn = 1'b1;
        wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        go = 1'b0; len = '0; acc_done = 1'b0;
        #1 rstn = 1'b0;
        #2 chk_all_zero("rst");
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // basic 4-element stream
        for (int i = 0; i < 4; i++) wr(1'b0, i, 8'(i + 1));
        for (int i = 0; i < 4; i++) wr(1'b1, i, 8'(i + 5));
        go_cmd(4);
        run(4, -1, dot);
        chk("dot_basic", dot, 70);
        chk("vlen4", vector_len, 4);
        finish_acc();

        // illegal lengths
        go_cmd(0);
        chk("err_len0", err_len, 1);
        chk("busy_len0", busy, 0);
        chk("vlen_keep0", vector_len, 4);
        go_cmd(17);
        chk("err_len17", err_len, 1);
        chk("busy_len17", busy, 0);
        chk("vlen_keep17", vector_len, 4);
        tick();
        chk("valid_err", vector_valid, 0);
        chk("wd_err", writes_done, 0);
        go_cmd(4);
        chk("err_clr", err_len, 0);
        run(4, -1, dot);
        chk("dot_rerun", dot, 70);
        finish_acc();

        // full depth, extreme values
        for (int i = 0; i < DEPTH; i++) wr(1'b0, i, -8'sd128);
        for (int i = 0; i < DEPTH; i++) wr(1'b1, i, 8'sd127);
        go_cmd(16);
        chk("vlen16", vector_len, 16);
        run(16, -1, dot);
        chk("dot_full", dot, -260096);
        finish_acc();

        // write, go (len 0) and acc_done during stream are all ignored
        go_cmd(4);
        run(4, 2, dot);
        chk("err_ignored", err_len, 0);
        finish_acc();
        go_cmd(4);
        run(4, -1, dot);
        chk("dot_nowrite", dot, -65024);
        finish_acc();

        // async reset during the stream
        go_cmd(4);
        tick();
        tick();
        tick();
        chk("valid_pre_rst", vector_valid, 1);
        rstn = 1'b0;
        #1;
        chk_all_zero("midrst");
        tick();
        rstn = 1'b1;
        tick();
        chk("busy_post_rst", busy, 0);
        wr(1'b0, 0, 8'sd10);
        wr(1'b0, 1, -8'sd20);
        wr(1'b0, 2, 8'sd30);
        wr(1'b0, 3, -8'sd40);
        for (int i = 0; i < 4; i++) wr(1'b1, i, 8'sd3);
        go_cmd(4);
        run(4, -1, dot);
        chk("dot_post_rst", dot, -60);
        finish_acc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
